credit_link_tx: RTL and testbench

- Downstream drain stage for the router's per-port large_buffer FIFO.
- Pops flits from the show-ahead FIFO and drives them onto an inter-router link with one registered stage.
- Link flow control is credit-based: one credit per free flit slot in the far-end input buffer.
- Packet-aware (wormhole): once a head flit is sent, the packet drains to its tail before a new packet can be gated off.

---
 rtl/credit_link_tx_if.sv | 29 ++
 rtl/credit_link_tx.sv | 113 +++++++++++
 tb/tb_credit_link_tx.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/credit_link_tx_if.sv
// credit_link_tx_if: FIFO-side and link-side signals of the credit link transmitter.
// Latency: none, wires only; all timing lives in credit_link_tx.
// Backpressure: fifo_consume pops the FIFO; credits flow back on credit_in.
interface credit_link_tx_if #(
    parameter int DATA_WIDTH = 64,
    parameter int CREDIT_W   = 4
);
    logic [DATA_WIDTH-1:0] fifo_out;
    logic                  fifo_empty;
    logic                  fifo_consume;
    logic                  link_enable;
    logic                  credit_in;
    logic [DATA_WIDTH-1:0] link_data;
    logic                  link_valid;
    logic [CREDIT_W-1:0]   credits;
    logic                  in_packet;
    logic                  credit_ovf;
    logic                  proto_err;

    modport master (
        input  fifo_out, fifo_empty, link_enable, credit_in,
        output fifo_consume, link_data, link_valid, credits, in_packet, credit_ovf, proto_err
    );

    modport slave (
        output fifo_out, fifo_empty, link_enable, credit_in,
        input  fifo_consume, link_data, link_valid, credits, in_packet, credit_ovf, proto_err
    );
endinterface

// File: rtl/credit_link_tx.sv
// credit_link_tx: drains a show-ahead FIFO onto a credit-flow-controlled link, wormhole packet-aware; optional framing check under CREDIT_LINK_PROTO_CHECK_EN.
// Latency: FIFO head to link_data/link_valid is exactly one cycle; one flit per cycle sustained.
// Backpressure: stalls on empty FIFO or zero credits; link_enable only gates the start of a packet.
module credit_link_tx #(
    parameter int DATA_WIDTH = 64,
    parameter int CREDIT_MAX = 8,
    parameter int CREDIT_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    credit_link_tx_if.master  lnk
);
    localparam logic [CREDIT_W-1:0] CREDIT_MAX_C = CREDIT_W'(CREDIT_MAX);

    typedef enum logic {
        IDLE = 1'b0,
        BODY = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] link_data_q, link_data_d;
    logic                  link_valid_q, link_valid_d;
    logic [CREDIT_W-1:0]   credits_q, credits_d;
    logic                  credit_ovf_q, credit_ovf_d;
    logic                  fire;
    logic                  flit_head;
    logic                  flit_tail;
    logic                  in_packet;

    assign flit_head = lnk.fifo_out[DATA_WIDTH-1];
    assign flit_tail = lnk.fifo_out[DATA_WIDTH-2];

    // link_enable matters only between packets; an open packet always drains.
    assign fire = ~lnk.fifo_empty & (credits_q != '0) & ((state_q == BODY) | lnk.link_enable);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            link_data_q  <= '0;
            link_valid_q <= 1'b0;
            credits_q    <= CREDIT_MAX_C;
            credit_ovf_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            link_data_q  <= link_data_d;
            link_valid_q <= link_valid_d;
            credits_q    <= credits_d;
            credit_ovf_q <= credit_ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (fire) begin
            case (state_q)
                IDLE:    if (flit_head && !flit_tail) state_d = BODY;
                BODY:    if (flit_tail)               state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        in_packet = (state_q == BODY);
    end

    always_comb begin
        link_data_d  = fire ? lnk.fifo_out : link_data_q;
        link_valid_d = fire;
        credits_d    = credits_q;
        credit_ovf_d = credit_ovf_q;
        // A returned credit with a simultaneous send cancels out; a return at full is an overflow.
        if (lnk.credit_in && !fire) begin
            if (credits_q == CREDIT_MAX_C) begin
                credit_ovf_d = 1'b1;
            end else begin
                credits_d = credits_q + CREDIT_W'(1);
            end
        end else if (!lnk.credit_in && fire) begin
            credits_d = credits_q - CREDIT_W'(1);
        end
    end

`ifdef CREDIT_LINK_PROTO_CHECK_EN
    logic proto_err_q, proto_err_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            proto_err_q <= 1'b0;
        end else begin
            proto_err_q <= proto_err_d;
        end
    end

    always_comb begin
        proto_err_d = proto_err_q;
        if (fire && (((state_q == IDLE) && !flit_head) || ((state_q == BODY) && flit_head))) begin
            proto_err_d = 1'b1;
        end
    end

    assign lnk.proto_err = proto_err_q;
`else
    assign lnk.proto_err = 1'b0;
`endif

    assign lnk.fifo_consume = fire;
    assign lnk.link_data    = link_data_q;
    assign lnk.link_valid   = link_valid_q;
    assign lnk.credits      = credits_q;
    assign lnk.in_packet    = in_packet;
    assign lnk.credit_ovf   = credit_ovf_q;
endmodule

// File: tb/tb_credit_link_tx.sv
// Directed bench for credit_link_tx: a small show-ahead FIFO model feeds the DUT,
// each scenario task drives vectors and checks hand-computed responses inline.
module tb_credit_link_tx;
    localparam int DW   = 64;
    localparam int CMAX = 8;
    localparam int CW   = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    credit_link_tx_if #(.DATA_WIDTH(DW), .CREDIT_W(CW)) ifc ();

    credit_link_tx #(.DATA_WIDTH(DW), .CREDIT_MAX(CMAX), .CREDIT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .lnk (ifc)
    );

    logic [DW-1:0] mem [0:63];
    logic [5:0]    rd_ptr;
    logic [5:0]    wr_ptr = '0;

    assign ifc.fifo_empty = (rd_ptr == wr_ptr);
    assign ifc.fifo_out   = mem[rd_ptr];

    always @(posedge clk or negedge rst) begin
        if (!rst) rd_ptr <= '0;
        else if (ifc.fifo_consume) rd_ptr <= rd_ptr + 6'd1;
    end

    task automatic push(input logic [DW-1:0] f);
        mem[wr_ptr] = f;
        wr_ptr = wr_ptr + 6'd1;
    endtask

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic give_credits(input int n);
        repeat (n) begin
            ifc.credit_in = 1'b1;
            to_drive();
        end
        ifc.credit_in = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        wr_ptr = '0;
        ifc.link_enable = 1'b0;
        ifc.credit_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (ifc.credits !== 4'd8) begin n_fail++; $display("FAIL reset_credits: got %0d expected 8", ifc.credits); end
        n_checks++; if (ifc.link_valid !== 1'b0) begin n_fail++; $display("FAIL reset_link_valid: got %b expected 0", ifc.link_valid); end
        n_checks++; if (ifc.fifo_consume !== 1'b0) begin n_fail++; $display("FAIL reset_consume: got %b expected 0", ifc.fifo_consume); end
        n_checks++; if (ifc.link_data !== 64'h0) begin n_fail++; $display("FAIL reset_link_data: got %h expected 0", ifc.link_data); end
        n_checks++; if (ifc.in_packet !== 1'b0) begin n_fail++; $display("FAIL reset_in_packet: got %b expected 0", ifc.in_packet); end
        n_checks++; if (ifc.credit_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_credit_ovf: got %b expected 0", ifc.credit_ovf); end
        n_checks++; if (ifc.proto_err !== 1'b0) begin n_fail++; $display("FAIL reset_proto_err: got %b expected 0", ifc.proto_err); end
        to_drive();
        rst = 1'b1;
        to_drive();
        @(negedge clk);
        n_checks++; if (ifc.credits !== 4'd8) begin n_fail++; $display("FAIL idle_credits: got %0d expected 8", ifc.credits); end
        n_checks++; if (ifc.link_valid !== 1'b0) begin n_fail++; $display("FAIL idle_link_valid: got %b expected 0", ifc.link_valid); end
        to_drive();
    endtask

    task automatic test_single_flit();
        push(64'hC000_0000_0000_00AA);
        ifc.link_enable = 1'b1;
        @(negedge clk);
        n_checks++; if (ifc.fifo_consume !== 1'b1) begin n_fail++; $display("FAIL single_consume: got %b expected 1", ifc.fifo_consume); end
        n_checks++; if (ifc.link_valid !== 1'b0) begin n_fail++; $display("FAIL single_pre_valid: got %b expected 0", ifc.link_valid); end
        to_drive();
        @(negedge clk);
        n_checks++; if (ifc.link_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b expected 1", ifc.link_valid); end
        n_checks++; if (ifc.link_data !== 64'hC000_0000_0000_00AA) begin n_fail++; $display("FAIL single_data: got %h expected c0000000000000aa", ifc.link_data); end
        n_checks++; if (ifc.credits !== 4'd7) begin n_fail++; $display("FAIL single_credits: got %0d expected 7", ifc.credits); end
        n_checks++; if (ifc.in_packet !== 1'b0) begin n_fail++; $display("FAIL single_in_packet: got %b expected 0", ifc.in_packet); end
        n_checks++; if (ifc.fifo_consume !== 1'b0) begin n_fail++; $display("FAIL single_consume_once: got %b expected 0", ifc.fifo_consume); end
        to_drive();
        @(negedge clk);
        n_checks++; if (ifc.link_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_drop: got %b expected 0", ifc.link_valid); end
        n_checks++; if (ifc.link_data !== 64'hC000_0000_0000_00AA) begin n_fail++; $display("FAIL single_data_hold: got %h expected c0000000000000aa", ifc.link_data); end
        to_drive();
        give_credits(1);
        @(negedge clk);
        n_checks++; if (ifc.credits !== 4'd8) begin n_fail++; $display("FAIL single_credit_return: got %0d expected 8", ifc.credits); end
        to_drive();
    endtask

    task automatic test_starvation();
        logic [11:0] mask;
        int          cnt;
        mask = '0;
        cnt  = 0;
        ifc.link_enable = 1'b1;
        push(64'h8000_0000_0000_0000);
        for (int i = 1; i <= 8; i++) push(64'(i));
        push(64'h4000_0000_0000_0009);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (ifc.fifo_consume) mask[c] = 1'b1;
            to_drive();
        end
        @(negedge clk);
        n_checks++; if (mask !== 12'h0FF) begin n_fail++; $display("FAIL starve_pattern: got %h expected 0ff", mask); end
        n_checks++; if (ifc.credits !== 4'd0) begin n_fail++; $display("FAIL starve_credits: got %0d expected 0", ifc.credits); end
        n_checks++; if (ifc.fifo_consume !== 1'b0) begin n_fail++; $display("FAIL starve_consume: got %b expected 0", ifc.fifo_consume); end
        n_checks++; if (ifc.in_packet !== 1'b1) begin n_fail++; $display("FAIL starve_in_packet: got %b expected 1", ifc.in_packet); end
        n_checks++; if (ifc.link_data !== 64'd7) begin n_fail++; $display("FAIL starve_last_data: got %h expected 7", ifc.link_data); end
        to_drive();
        give_credits(1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (ifc.fifo_consume) cnt++;
            to_drive();
        end
        @(negedge clk);
        n_checks++; if (cnt !== 1) begin n_fail++; $display("FAIL starve_one_more: got %0d expected 1", cnt); end
        n_checks++; if (ifc.credits !== 4'd0) begin n_fail++; $display("FAIL starve_credits_again: got %0d expected 0", ifc.credits); end
        n_checks++; if (ifc.link_data !== 64'd8) begin n_fail++; $display("FAIL starve_ninth_data: got %h expected 8", ifc.link_data); end
        to_drive();
        give_credits(9);
        @(negedge clk);
        n_checks++; if (ifc.credits !== 4'd8) begin n_fail++; $display("FAIL starve_refill: got %0d expected 8", ifc.credits); end
        n_checks++; if (ifc.in_packet !== 1'b0) begin n_fail++; $display("FAIL starve_tail_close: got %b expected 0", ifc.in_packet); end
        n_checks++; if (ifc.link_data !== 64'h4000_0000_0000_0009) begin n_fail++; $display("FAIL starve_tail_data: got %h expected 4000000000000009", ifc.link_data); end
        to_drive();
    endtask

    task automatic test_midpacket_gate();
        int cnt;
        cnt = 0;
        ifc.link_enable = 1'b1;
        push(64'h8000_0000_0000_0010);
        push(64'h0000_0000_0000_0011);
        push(64'h0000_0000_0000_0012);
        push(64'h0000_0000_0000_0013);
        push(64'h4000_0000_0000_0014);
        push(64'h8000_0000_0000_0020);
        @(negedge clk);
        n_checks++; if (ifc.fifo_consume !== 1'b1) begin n_fail++; $display("FAIL mid_head_consume: got %b expected 1", ifc.fifo_consume); end
        to_drive();
        ifc.link_enable = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 0) begin
                n_checks++; if (ifc.in_packet !== 1'b1) begin n_fail++; $display("FAIL mid_in_packet: got %b expected 1", ifc.in_packet); end
            end
            if (ifc.fifo_consume) cnt++;
            to_drive();
        end
        @(negedge clk);
        n_checks++; if (cnt !== 4) begin n_fail++; $display("FAIL mid_drain_count: got %0d expected 4", cnt); end
        n_checks++; if (ifc.in_packet !== 1'b0) begin n_fail++; $display("FAIL mid_in_packet_fall: got %b expected 0", ifc.in_packet); end
        n_checks++; if (ifc.link_data !== 64'h4000_0000_0000_0014) begin n_fail++; $display("FAIL mid_tail_data: got %h expected 4000000000000014", ifc.link_data); end
        n_checks++; if (ifc.fifo_consume !== 1'b0) begin n_fail++; $display("FAIL mid_next_head_held: got %b expected 0", ifc.fifo_consume); end
        n_checks++; if (ifc.credits !== 4'd3) begin n_fail++; $display("FAIL mid_credits: got %0d expected 3", ifc.credits); end
        to_drive();
        ifc.link_enable = 1'b1;
        push(64'h4000_0000_0000_0021);
        @(negedge clk);
        n_checks++; if (ifc.fifo_consume !== 1'b1) begin n_fail++; $display("FAIL mid_reenable_consume: got %b expected 1", ifc.fifo_consume); end
        to_drive();
        @(negedge clk);
        n_checks++; if (ifc.in_packet !== 1'b1) begin n_fail++; $display("FAIL mid_second_open: got %b expected 1", ifc.in_packet); end
        to_drive();
        @(negedge clk);
        n_checks++; if (ifc.credits !== 4'd1) begin n_fail++; $display("FAIL mid_second_credits: got %0d expected 1", ifc.credits); end
        n_checks++; if (ifc.in_packet !== 1'b0) begin n_fail++; $display("FAIL mid_second_close: got %b expected 0", ifc.in_packet); end
        to_drive();
        give_credits(7);
    endtask

    task automatic test_credit_arith();
        ifc.link_enable = 1'b1;
        push(64'hC000_0000_0000_0001);
        push(64'hC000_0000_0000_0002);
        push(64'hC000_0000_0000_0003);
        repeat (3) to_drive();
        @(negedge clk);
        n_checks++; if (ifc.credits !== 4'd5) begin n_fail++; $display("FAIL arith_at_five: got %0d expected 5", ifc.credits); end
        to_drive();
        push(64'hC000_0000_0000_0004);
        ifc.credit_in = 1'b1;
        @(negedge clk);
        n_checks++; if (ifc.fifo_consume !== 1'b1) begin n_fail++; $display("FAIL arith_simul_consume: got %b expected 1", ifc.fifo_consume); end
        to_drive();
        ifc.credit_in = 1'b0;
        @(negedge clk);
        n_checks++; if (ifc.credits !== 4'd5) begin n_fail++; $display("FAIL arith_simul_credits: got %0d expected 5", ifc.credits); end
        n_checks++; if (ifc.link_data !== 64'hC000_0000_0000_0004) begin n_fail++; $display("FAIL arith_simul_data: got %h expected c000000000000004", ifc.link_data); end
        to_drive();
        give_credits(3);
        @(negedge clk);
        n_checks++; if (ifc.credits !== 4'd8) begin n_fail++; $display("FAIL arith_full: got %0d expected 8", ifc.credits); end
        n_checks++; if (ifc.credit_ovf !== 1'b0) begin n_fail++; $display("FAIL arith_no_ovf: got %b expected 0", ifc.credit_ovf); end
        to_drive();
        give_credits(1);
        @(negedge clk);
        n_checks++; if (ifc.credits !== 4'd8) begin n_fail++; $display("FAIL arith_ovf_credits: got %0d expected 8", ifc.credits); end
        n_checks++; if (ifc.credit_ovf !== 1'b1) begin n_fail++; $display("FAIL arith_ovf_set: got %b expected 1", ifc.credit_ovf); end
        to_drive();
        to_drive();
        @(negedge clk);
        n_checks++; if (ifc.credit_ovf !== 1'b1) begin n_fail++; $display("FAIL arith_ovf_sticky: got %b expected 1", ifc.credit_ovf); end
        to_drive();
    endtask

    task automatic test_async_reset();
        ifc.link_enable = 1'b1;
        push(64'h8000_0000_0000_0030);
        push(64'h0000_0000_0000_0031);
        to_drive();
        to_drive();
        @(negedge clk);
        n_checks++; if (ifc.in_packet !== 1'b1) begin n_fail++; $display("FAIL arst_open: got %b expected 1", ifc.in_packet); end
        n_checks++; if (ifc.credits !== 4'd6) begin n_fail++; $display("FAIL arst_pre_credits: got %0d expected 6", ifc.credits); end
        #2;
        rst = 1'b0;
        wr_ptr = '0;
        #1;
        n_checks++; if (ifc.in_packet !== 1'b0) begin n_fail++; $display("FAIL arst_in_packet: got %b expected 0", ifc.in_packet); end
        n_checks++; if (ifc.credits !== 4'd8) begin n_fail++; $display("FAIL arst_credits: got %0d expected 8", ifc.credits); end
        n_checks++; if (ifc.link_valid !== 1'b0) begin n_fail++; $display("FAIL arst_link_valid: got %b expected 0", ifc.link_valid); end
        n_checks++; if (ifc.link_data !== 64'h0) begin n_fail++; $display("FAIL arst_link_data: got %h expected 0", ifc.link_data); end
        n_checks++; if (ifc.credit_ovf !== 1'b0) begin n_fail++; $display("FAIL arst_ovf_clear: got %b expected 0", ifc.credit_ovf); end
        to_drive();
        rst = 1'b1;
        to_drive();
    endtask

    task automatic test_proto_check();
        logic exp_err;
`ifdef CREDIT_LINK_PROTO_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        ifc.link_enable = 1'b1;
        push(64'h0000_0000_0000_0055);
        @(negedge clk);
        n_checks++; if (ifc.fifo_consume !== 1'b1) begin n_fail++; $display("FAIL proto_body_sent: got %b expected 1", ifc.fifo_consume); end
        n_checks++; if (ifc.proto_err !== 1'b0) begin n_fail++; $display("FAIL proto_pre: got %b expected 0", ifc.proto_err); end
        to_drive();
        @(negedge clk);
        n_checks++; if (ifc.proto_err !== exp_err) begin n_fail++; $display("FAIL proto_set: got %b expected %b", ifc.proto_err, exp_err); end
        n_checks++; if (ifc.in_packet !== 1'b0) begin n_fail++; $display("FAIL proto_state_kept: got %b expected 0", ifc.in_packet); end
        n_checks++; if (ifc.link_data !== 64'h55) begin n_fail++; $display("FAIL proto_data: got %h expected 55", ifc.link_data); end
        repeat (3) to_drive();
        @(negedge clk);
        n_checks++; if (ifc.proto_err !== exp_err) begin n_fail++; $display("FAIL proto_sticky: got %b expected %b", ifc.proto_err, exp_err); end
        rst = 1'b0;
        wr_ptr = '0;
        #1;
        n_checks++; if (ifc.proto_err !== 1'b0) begin n_fail++; $display("FAIL proto_reset_clear: got %b expected 0", ifc.proto_err); end
        to_drive();
        rst = 1'b1;
        to_drive();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        ifc.link_enable = 1'b0;
        ifc.credit_in   = 1'b0;
        test_reset();
        test_single_flit();
        test_starvation();
        test_midpacket_gate();
        test_credit_arith();
        test_async_reset();
        test_proto_check();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
